uart_id_receiver: RTL and testbench

Oversampling UART receiver that turns the serial byte stream from the voice-recognition front-end into a validated 6-bit command/digit ID with a one-cycle strobe. It runs on the system clock, not a baud clock. It sits directly upstream of `DigitTo7SegmentDisplay` and drives its `ID[5:0]` input. Bits arrive MSB first, so the byte is assembled in wire order and downstream logic needs no bit reversal.

---
 rtl/uart_id_receiver.sv | 166 ++++++++++++++++
 tb/tb_uart_id_receiver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_id_receiver.sv
// Oversampling UART receiver (MSB first) that validates each byte as a 6-bit command/digit ID.
// Emits one-cycle strobes for an accepted ID, an out-of-range byte, or a bad stop bit.
module uart_id_receiver #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MAX_ID       = 47
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic [5:0] ID,
    output logic       id_valid,
    output logic       id_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       MAX_ID_B = 8'(MAX_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic [5:0]       id_q, id_d;
    logic             id_valid_q, id_valid_d;
    logic             id_err_q, id_err_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q, rx_busy_d;
    logic             rx_meta_q, rx_s_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            id_q        <= '0;
            id_valid_q  <= 1'b0;
            id_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            id_q        <= id_d;
            id_valid_q  <= id_valid_d;
            id_err_q    <= id_err_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        id_d        = id_q;
        id_valid_d  = 1'b0;
        id_err_d    = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Recheck at mid start bit; a high line here is a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    shreg_d = {shreg_q[6:0], rx_s_q};
                    cnt_d   = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shreg_q;
                        state_d = S_IDLE;
                        if (shreg_q <= MAX_ID_B) begin
                            id_d       = shreg_q[5:0];
                            id_valid_d = 1'b1;
                        end else begin
                            id_err_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                // Hold off retriggering until a break / stuck-low line releases.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    assign data      = data_q;
    assign ID        = id_q;
    assign id_valid  = id_valid_q;
    assign id_err    = id_err_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_id_receiver.sv
// Self-checking bench for uart_id_receiver: directed scenarios plus random frames
// scored against an event-level model of what each frame should produce.
module tb_uart_id_receiver;

    localparam int unsigned CPB   = 16;
    localparam int unsigned MAXID = 47;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic [5:0] ID;
    logic       id_valid;
    logic       id_err;
    logic       frame_err;
    logic       rx_busy;

    uart_id_receiver #(.CLKS_PER_BIT(CPB), .MAX_ID(MAXID)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .ID        (ID),
        .id_valid  (id_valid),
        .id_err    (id_err),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = id_valid, 1 = id_err, 2 = frame_err
    typedef struct {
        int kind;
        int dat;
        int id;
    } ev_t;

    ev_t  exp_q[$];
    int   pulse_cycs[$];
    int   model_id   = 0;
    int   model_data = 0;
    int   total      = 0;
    int   bad        = 0;
    int   pulse_cnt  = 0;
    int   last_pulse_cyc = -1;
    int   rise_cyc = -1;
    int   fall_cyc = -1;
    int   rise_cnt = 0;
    int   start_cyc = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pulse and busy-edge monitor; each pulse is matched against the model's queue.
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (reset) begin
            busy_prev = 1'b0;
        end else begin
            if (rx_busy && !busy_prev) begin
                rise_cyc = cyc;
                rise_cnt++;
            end
            if (!rx_busy && busy_prev) fall_cyc = cyc;
            busy_prev = rx_busy;
            if (id_valid || id_err || frame_err) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
                pulse_cycs.push_back(cyc);
                check("onehot", 32'(id_valid) + 32'(id_err) + 32'(frame_err), 32'd1);
                k = id_valid ? 0 : (id_err ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(k), 32'd99);
                end else begin
                    e = exp_q.pop_front();
                    check("kind", 32'(k), 32'(e.kind));
                    check("data", 32'(data), 32'(e.dat));
                    check("ID", 32'(ID), 32'(e.id));
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one MSB-first frame; a low stop bit is held low_extra more clocks before release.
    task automatic send(input logic [7:0] b, input logic stop, input int low_extra);
        ev_t e;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        if (stop) begin
            model_data = int'(b);
            if (int'(b) <= int'(MAXID)) begin
                model_id = int'(b);
                e.kind = 0;
            end else begin
                e.kind = 1;
            end
        end else begin
            e.kind = 2;
        end
        e.dat = model_data;
        e.id  = model_id;
        exp_q.push_back(e);
        drive_bit(stop);
        if (!stop) begin
            repeat (low_extra) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},  32'(data), 32'd0);
        check({tag, "_ID"},    32'(ID), 32'd0);
        check({tag, "_pulses"}, 32'(id_valid) + 32'(id_err) + 32'(frame_err), 32'd0);
        check({tag, "_busy"},  32'(rx_busy), 32'd0);
    endtask

    initial begin
        int pc0, rc0, s, lat, hi;
        logic [7:0] b;
        logic       stop;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("rst");
        idle(50);
        check("idle_busy_rises", 32'(rise_cnt), 32'd0);

        // Single legal byte: latency, busy window, outputs
        pc0 = pulse_cnt;
        rc0 = rise_cnt;
        send(8'd5, 1'b1, 0);
        idle(20);
        lat = last_pulse_cyc - start_cyc;
        check("lat5", (lat >= 154 && lat <= 156) ? 32'd155 : 32'(lat), 32'd155);
        check("busy_rise_lat", 32'(rise_cyc - start_cyc), 32'd3);
        check("busy_fall_at_pulse", 32'(fall_cyc), 32'(last_pulse_cyc));
        check("busy_one_window", 32'(rise_cnt - rc0), 32'd1);
        check("pulses5", 32'(pulse_cnt - pc0), 32'd1);
        check("ID5", 32'(ID), 32'd5);
        check("data5", 32'(data), 32'h05);

        // Back-to-back frames
        pc0 = pulse_cnt;
        send(8'd13, 1'b1, 0);
        send(8'd35, 1'b1, 0);
        send(8'd44, 1'b1, 0);
        send(8'd46, 1'b1, 0);
        idle(20);
        check("b2b_pulses", 32'(pulse_cnt - pc0), 32'd4);
        for (int i = 0; i < 3; i++) begin
            if (pulse_cycs.size() > pc0 + i + 1)
                check("b2b_spacing", 32'(pulse_cycs[pc0+i+1] - pulse_cycs[pc0+i]), 32'd160);
        end
        check("ID46", 32'(ID), 32'd46);

        // Start-bit glitch
        pc0 = pulse_cnt;
        rc0 = rise_cnt;
        s   = cyc;
        rx  = 1'b0;
        idle(5);
        rx  = 1'b1;
        idle(30);
        check("glitch_busy_rose", 32'(rise_cnt - rc0), 32'd1);
        check("glitch_busy_rise", 32'(rise_cyc - s), 32'd3);
        check("glitch_busy_fall", 32'(fall_cyc - s), 32'd11);
        check("glitch_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
        check("glitch_ID", 32'(ID), 32'd46);

        // Framing error with a stuck-low line, then recovery
        pc0 = pulse_cnt;
        send(8'd30, 1'b0, 40);
        hi = cyc;
        check("ferr_busy_held", 32'(rx_busy), 32'd1);
        idle(10);
        check("ferr_pulses", 32'(pulse_cnt - pc0), 32'd1);
        check("ferr_busy_release", 32'(fall_cyc - hi), 32'd3);
        check("ferr_ID", 32'(ID), 32'd46);
        send(8'd38, 1'b1, 0);
        idle(20);
        check("ID38", 32'(ID), 32'd38);

        // Out-of-range byte, then reset mid-frame
        send(8'd200, 1'b1, 0);
        idle(5);
        check("err_ID", 32'(ID), 32'd38);
        check("err_data", 32'(data), 32'hC8);
        pc0 = pulse_cnt;
        b = 8'd7;
        drive_bit(1'b0);
        for (int i = 7; i >= 4; i--) drive_bit(b[i]);
        reset = 1'b1;
        rx    = 1'b1;
        idle(3);
        reset = 1'b0;
        model_id   = 0;
        model_data = 0;
        exp_q.delete();
        check_reset_values("midrst");
        idle(200);
        check("aborted_no_pulse", 32'(pulse_cnt - pc0), 32'd0);

        // Random frames against the model
        for (int n = 0; n < 25; n++) begin
            b    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, MAXID)) : 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            send(b, stop, int'($urandom_range(0, 30)));
            idle(stop ? int'($urandom_range(0, 8)) : int'($urandom_range(2, 10)));
        end
        idle(200);
        check("drain", 32'(exp_q.size()), 32'd0);
        check("final_ID", 32'(ID), 32'(model_id));
        check("final_data", 32'(data), 32'(model_data));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
